// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: control/datapath bundle for the multicycle control sequencer.
// master: sequencer side. It takes op, Zero and mem_ready, and drives the strobes, mux selects,
//         illegal and instret.
// slave : datapath side, with the opposite directions.
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 32
) ();
    logic [6:0]       op;
    logic             Zero;
    logic             mem_ready;
    logic             mem_req;
    logic             PCWrite;
    logic             AdrSrc;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       ImmSrc;
    logic             illegal;
    logic [CNT_W-1:0] instret;
    modport master (
        input  op, Zero, mem_ready,
        output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, instret
    );
    modport slave (
        output op, Zero, mem_ready,
        input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, instret
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore sequencer that steps RV32I instructions through the multicycle datapath.
// Ports:
//   clk    rising-edge clock.
//   rst_n  synchronous, active-low reset.
//   bus    master modport. Inputs are op, Zero and mem_ready. Outputs are the strobes, the mux
//          selects, ImmSrc, the sticky illegal flag and the instret counter.
// Define MC_FSM_JAL_EN to decode jal (op 1101111). Without it, jal traps.
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst_n,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
`ifdef MC_FSM_JAL_EN
        JAL      = 4'd10,
`endif
        TRAP     = 4'd11
    } stateT;

    stateT            state, nextState, decodeNext;
    logic             illegalQ;
    logic [CNT_W-1:0] instretQ;
    logic             memReq, pcWrite, adrSrc, memWrite, irWrite, regWrite, retire;
    logic [1:0]       resultSrc, aluSrcA, aluSrcB, aluOp, immSrc;

    always_comb begin
        decodeNext = TRAP;
        immSrc     = 2'b00;
        case (bus.op)
            7'b0000011: decodeNext = MEMADR;
            7'b0100011: begin
                decodeNext = MEMADR;
                immSrc     = 2'b01;
            end
            7'b0110011: decodeNext = EXECUTER;
            7'b0010011: decodeNext = EXECUTEI;
            7'b1100011: begin
                decodeNext = BEQ;
                immSrc     = 2'b10;
            end
`ifdef MC_FSM_JAL_EN
            7'b1101111: begin
                decodeNext = JAL;
                immSrc     = 2'b11;
            end
`endif
            default: decodeNext = TRAP;
        endcase
    end

    always_comb begin
        nextState = state;
        memReq    = 1'b0;
        pcWrite   = 1'b0;
        adrSrc    = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        regWrite  = 1'b0;
        resultSrc = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        aluOp     = 2'b00;
        case (state)
            FETCH: begin
                memReq    = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                irWrite   = bus.mem_ready;
                pcWrite   = bus.mem_ready;
                nextState = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                aluSrcA   = 2'b01;
                aluSrcB   = 2'b01;
                nextState = decodeNext;
            end
            MEMADR: begin
                aluSrcA   = 2'b10;
                aluSrcB   = 2'b01;
                nextState = (bus.op == 7'b0000011) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                memReq    = 1'b1;
                adrSrc    = 1'b1;
                nextState = bus.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
                nextState = FETCH;
            end
            MEMWRITE: begin
                memReq    = 1'b1;
                adrSrc    = 1'b1;
                memWrite  = bus.mem_ready;
                nextState = bus.mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                aluSrcA   = 2'b10;
                aluOp     = 2'b10;
                nextState = ALUWB;
            end
            EXECUTEI: begin
                aluSrcA   = 2'b10;
                aluSrcB   = 2'b01;
                aluOp     = 2'b10;
                nextState = ALUWB;
            end
            ALUWB: begin
                regWrite  = 1'b1;
                nextState = FETCH;
            end
            BEQ: begin
                aluSrcA   = 2'b10;
                aluOp     = 2'b01;
                pcWrite   = bus.Zero;
                nextState = FETCH;
            end
`ifdef MC_FSM_JAL_EN
            JAL: begin
                aluSrcA   = 2'b01;
                aluSrcB   = 2'b10;
                pcWrite   = 1'b1;
                nextState = ALUWB;
            end
`endif
            TRAP:    nextState = TRAP;
            default: nextState = TRAP;
        endcase
        // While in reset, all strobes are held low and the selects show their FETCH values.
        if (!rst_n) begin
            nextState = FETCH;
            memReq    = 1'b0;
            pcWrite   = 1'b0;
            adrSrc    = 1'b0;
            memWrite  = 1'b0;
            irWrite   = 1'b0;
            regWrite  = 1'b0;
            resultSrc = 2'b10;
            aluSrcA   = 2'b00;
            aluSrcB   = 2'b10;
            aluOp     = 2'b00;
        end
    end

    // An instruction retires when it returns to FETCH from a terminal state.
    // A jal passes through ALUWB, so it is counted once.
    assign retire = (nextState == FETCH) && (state inside {MEMWB, MEMWRITE, ALUWB, BEQ});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            illegalQ <= 1'b0;
            instretQ <= '0;
        end else begin
            state    <= nextState;
            illegalQ <= illegalQ | (nextState == TRAP);
            if (retire) instretQ <= instretQ + CNT_W'(1);
        end
    end

    assign bus.mem_req   = memReq;
    assign bus.PCWrite   = pcWrite;
    assign bus.AdrSrc    = adrSrc;
    assign bus.MemWrite  = memWrite;
    assign bus.IRWrite   = irWrite;
    assign bus.RegWrite  = regWrite;
    assign bus.ResultSrc = resultSrc;
    assign bus.ALUSrcA   = aluSrcA;
    assign bus.ALUSrcB   = aluSrcB;
    assign bus.ALUOp     = aluOp;
    assign bus.ImmSrc    = immSrc;
    assign bus.illegal   = illegalQ;
    assign bus.instret   = instretQ;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: table-driven, scoreboarded bench for multicycle_control_fsm.
module tb_multicycle_control_fsm;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011, OP_B = 7'b1100011, OP_J = 7'b1101111, OP_X = 7'b0000000;
    // Bit order: {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal}
    localparam logic [14:0] F1    = 15'b110010_10_00_10_00_0;
    localparam logic [14:0] F0    = 15'b100000_10_00_10_00_0;
    localparam logic [14:0] DEC   = 15'b000000_00_01_01_00_0;
    localparam logic [14:0] MADR  = 15'b000000_00_10_01_00_0;
    localparam logic [14:0] MRD   = 15'b101000_00_00_00_00_0;
    localparam logic [14:0] MWB   = 15'b000001_01_00_00_00_0;
    localparam logic [14:0] MWR1  = 15'b101100_00_00_00_00_0;
    localparam logic [14:0] MWR0  = 15'b101000_00_00_00_00_0;
    localparam logic [14:0] EXR   = 15'b000000_00_10_00_10_0;
    localparam logic [14:0] EXI   = 15'b000000_00_10_01_10_0;
    localparam logic [14:0] AWB   = 15'b000001_00_00_00_00_0;
    localparam logic [14:0] BEQZ1 = 15'b010000_00_10_00_01_0;
    localparam logic [14:0] BEQZ0 = 15'b000000_00_10_00_01_0;
    localparam logic [14:0] JALS  = 15'b010000_00_01_10_00_0;
    localparam logic [14:0] TRAPS = 15'b000000_00_00_00_00_1;
    localparam logic [14:0] RST   = 15'b000000_10_00_10_00_0;
    localparam logic [14:0] RSTI  = 15'b000000_10_00_10_00_1;

    typedef struct {
        logic        rstn;
        logic [6:0]  op;
        logic        z;
        logic        rdy;
        logic [14:0] exp;
        logic        ret;
    } vecT;
    typedef struct {
        logic [16:0] w;
        logic [31:0] cnt;
    } expT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          stepNo = 0;
    logic [31:0] expRet = '0;
    expT         sbQ[$];
    vecT         tbl[$];

    multicycle_control_fsm_if #(.CNT_W(32)) bus ();
    multicycle_control_fsm_if #(.CNT_W(4))  bus4 ();
    assign bus4.op        = bus.op;
    assign bus4.Zero      = bus.Zero;
    assign bus4.mem_ready = bus.mem_ready;

    multicycle_control_fsm #(.CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    multicycle_control_fsm #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    function automatic logic [1:0] immExp(input logic [6:0] op);
        if (op == OP_S) return 2'b01;
        if (op == OP_B) return 2'b10;
`ifdef MC_FSM_JAL_EN
        if (op == OP_J) return 2'b11;
`endif
        return 2'b00;
    endfunction

    function automatic void add(input logic rstn, input logic [6:0] op, input logic z, input logic rdy,
                                input logic [14:0] exp, input logic ret);
        vecT v;
        v.rstn = rstn;
        v.op   = op;
        v.z    = z;
        v.rdy  = rdy;
        v.exp  = exp;
        v.ret  = ret;
        tbl.push_back(v);
    endfunction

    task automatic step(input vecT v);
        expT         e;
        expT         got;
        logic [16:0] outs;
        @(negedge clk);
        rst_n         = v.rstn;
        bus.op        = v.op;
        bus.Zero      = v.z;
        bus.mem_ready = v.rdy;
        got.w   = {v.exp, immExp(v.op)};
        got.cnt = expRet;
        sbQ.push_back(got);
        #1;
        e = sbQ.pop_front();
        outs = {bus.mem_req, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.illegal, bus.ImmSrc};
        checks++;
        if (outs !== e.w) begin
            errors++;
            $display("FAIL outputs step %0d: got %b want %b", stepNo, outs, e.w);
        end
        checks++;
        if (bus.instret !== e.cnt) begin
            errors++;
            $display("FAIL instret step %0d: got %0d want %0d", stepNo, bus.instret, e.cnt);
        end
        checks++;
        if (bus4.instret !== e.cnt[3:0]) begin
            errors++;
            $display("FAIL instret4 step %0d: got %0d want %0d", stepNo, bus4.instret, e.cnt[3:0]);
        end
        if (!v.rstn) expRet = '0;
        else if (v.ret) expRet = expRet + 32'd1;
        stepNo++;
    endtask

    task automatic run(input logic rstn, input logic [6:0] op, input logic z, input logic rdy,
                       input logic [14:0] exp, input logic ret);
        vecT v;
        v.rstn = rstn;
        v.op   = op;
        v.z    = z;
        v.rdy  = rdy;
        v.exp  = exp;
        v.ret  = ret;
        step(v);
    endtask

    initial begin
        int n;
        bus.op        = OP_R;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        add(1, OP_R, 0, 1, F1, 0);   add(1, OP_R, 0, 0, DEC, 0);
        add(1, OP_R, 0, 1, EXR, 0);  add(1, OP_R, 0, 0, AWB, 1);
        add(1, OP_I, 0, 1, F1, 0);   add(1, OP_I, 1, 1, DEC, 0);
        add(1, OP_I, 0, 0, EXI, 0);  add(1, OP_I, 0, 1, AWB, 1);
        add(1, OP_L, 0, 1, F1, 0);   add(1, OP_L, 0, 1, DEC, 0);   add(1, OP_L, 0, 1, MADR, 0);
        add(1, OP_L, 0, 0, MRD, 0);  add(1, OP_L, 0, 0, MRD, 0);   add(1, OP_L, 0, 1, MRD, 0);
        add(1, OP_L, 0, 0, MWB, 1);
        add(1, OP_S, 0, 0, F0, 0);   add(1, OP_S, 0, 1, F1, 0);    add(1, OP_S, 0, 1, DEC, 0);
        add(1, OP_S, 0, 1, MADR, 0); add(1, OP_S, 0, 0, MWR0, 0);  add(1, OP_S, 0, 1, MWR1, 1);
        add(1, OP_B, 1, 1, F1, 0);   add(1, OP_B, 1, 1, DEC, 0);   add(1, OP_B, 1, 1, BEQZ1, 1);
        add(1, OP_B, 0, 1, F1, 0);   add(1, OP_B, 1, 1, DEC, 0);   add(1, OP_B, 0, 1, BEQZ0, 1);
`ifdef MC_FSM_JAL_EN
        add(1, OP_J, 0, 1, F1, 0);   add(1, OP_J, 0, 1, DEC, 0);
        add(1, OP_J, 0, 0, JALS, 0); add(1, OP_J, 0, 1, AWB, 1);
`else
        add(1, OP_J, 0, 1, F1, 0);   add(1, OP_J, 0, 1, DEC, 0);
        add(1, OP_J, 0, 1, TRAPS, 0); add(1, OP_J, 0, 1, TRAPS, 0);
        add(0, OP_J, 0, 1, RSTI, 0);
`endif
        add(1, OP_X, 0, 1, F1, 0);   add(1, OP_X, 0, 1, DEC, 0);
        for (int k = 0; k < 20; k++) add(1, OP_X, k[0], k[1], TRAPS, 0);
        add(0, OP_X, 0, 1, RSTI, 0);
        add(1, OP_L, 0, 1, F1, 0);   add(1, OP_L, 0, 1, DEC, 0);   add(1, OP_L, 0, 1, MADR, 0);
        add(1, OP_L, 0, 0, MRD, 0);  add(0, OP_L, 0, 1, RST, 0);
        add(1, OP_R, 0, 1, F1, 0);   add(1, OP_R, 0, 1, DEC, 0);
        add(1, OP_R, 0, 1, EXR, 0);  add(1, OP_R, 0, 1, AWB, 1);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        // A store that waits a random number of cycles with mem_req and AdrSrc held.
        run(1, OP_S, 0, 1, F1, 0);
        run(1, OP_S, 0, 1, DEC, 0);
        run(1, OP_S, 0, 1, MADR, 0);
        n = int'($urandom_range(1, 4));
        for (int k = 0; k < n; k++) run(1, OP_S, 0, 0, MWR0, 0);
        run(1, OP_S, 0, 1, MWR1, 1);
        // Sixteen branches. These wrap the 4-bit counter.
        for (int k = 0; k < 16; k++) begin
            run(1, OP_B, k[0], 1, F1, 0);
            run(1, OP_B, 0, 1, DEC, 0);
            run(1, OP_B, k[0], 0, k[0] ? BEQZ1 : BEQZ0, 1);
        end
        run(1, OP_R, 0, 1, F1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multicycle successor to the single-cycle control decoder. A Moore-style state machine sequences each RV32I instruction through fetch, decode, execute, memory and writeback cycles, and drives the datapath mux selects and write strobes. It waits on a memory ready handshake and counts retired instructions. It sits between the instruction register and the shared-memory multicycle datapath.

## Interface
- CNT_W, 32, width of the retired-instruction counter.
- clk  in  1  rising-edge clock; only clock in the block.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- op  in  7  opcode field from the instruction register.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_req  out  1  memory access request.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result.
- MemWrite  out  1  data memory write strobe.
- IRWrite  out  1  instruction register / old-PC enable.
- RegWrite  out  1  register file write strobe.
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result.
- ALUSrcA  out  2  00 = PC, 01 = old PC, 10 = rs1 data.
- ALUSrcB  out  2  00 = rs2 data, 01 = immediate, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded.
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- illegal  out  1  sticky: an unsupported opcode was decoded.
- instret  out  CNT_W  count of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP. Encoding is 4 bits, with FETCH = 0.
- Unlisted outputs are 0 in each state.
- FETCH:
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Goes to DECODE when mem_ready=1; otherwise stays.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL. Any other opcode -> TRAP.
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - Goes to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD:
  - Outputs: mem_req=1, AdrSrc=1, ResultSrc=00.
  - Holds until mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1; goes to FETCH.
- MEMWRITE:
  - Outputs: mem_req=1, AdrSrc=1, MemWrite=mem_ready.
  - Holds until mem_ready, then goes to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; goes to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1; goes to FETCH.
- BEQ:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero.
  - Goes to FETCH.
- JAL:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  - Goes to ALUWB.
- TRAP: all strobes 0; illegal=1; no exit except reset.
- ImmSrc is combinational from op in every state: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, otherwise 00.
- instret:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Wraps modulo 2^CNT_W.
  - A JAL retires on its ALUWB -> FETCH transition, so it counts once.

## Timing
- Reset: while rst_n=0 at a clk edge, state <= FETCH, instret <= 0, illegal <= 0.
- Strobes are forced to 0 while rst_n is low: mem_req, PCWrite, MemWrite, IRWrite, RegWrite.
- Mux selects show the FETCH values during reset.
- Reset mid-instruction (including in TRAP or while waiting on memory) abandons the instruction with no count. The first fetch starts on the cycle after rst_n rises.
- Strobes are combinational from the registered state plus mem_ready/Zero. No registered output delay.
- Latency with mem_ready held high:
  - lw: 5 cycles.
  - sw, R-type, I-type ALU, jal: 4 cycles.
  - beq: 3 cycles.
- Each cycle mem_ready is low inside FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_ready is ignored in all other states.
- mem_req stays high and AdrSrc stays stable through the entire wait.

## Configuration
- MC_FSM_JAL_EN defined: the JAL state exists and op 1101111 is decoded as above.
- MC_FSM_JAL_EN undefined: 1101111 goes to TRAP and ImmSrc never drives 11.

## Test plan
- Reset pulse, then mem_ready=1, op=0110011 -> FETCH, DECODE, EXECUTER, ALUWB with RegWrite=1 in cycle 4; instret=1 after cycle 4.
- op=0000011, mem_ready low for 2 cycles in MEMREAD -> mem_req and AdrSrc=1 held 3 cycles; RegWrite once in MEMWB; total 7 cycles.
- op=1100011 with Zero=1, then with Zero=0 -> PCWrite=1 in BEQ, then PCWrite=0; both increment instret.
- op=0000000 -> illegal=1 from the cycle after DECODE and stays in TRAP for 20 cycles; rst_n low then clears illegal and instret.
- instret preloaded to all-ones (force CNT_W=4, 15 instructions) -> 16th retire wraps instret to 0.
- op=1101111 with macro defined -> JAL then ALUWB, PCWrite=1, ImmSrc=11; with macro undefined -> TRAP.
